// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central sequencer for the 5-stage pipeline
// Prioritised hazard resolution, halt state and saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memcuDRE,
    input  logic             memcuDWE,
    input  logic             memcuHALT,
    input  logic             exMemToReg,
    input  logic             exWEN,
    input  logic [4:0]       exwsel,
    input  logic [4:0]       idrs,
    input  logic [4:0]       idrt,
    input  logic             exBranchTaken,
    input  logic             exJump,
    output logic             pcW,
    output logic             ifidW,
    output logic             idexW,
    output logic             exmemW,
    output logic             memwbW,
    output logic             ifidRST,
    output logic             idexRST,
    output logic             exmemRST,
    output logic             memwbRST,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state, nextState;
    logic   dstall, loadUse, redir;
    logic   countStall, countFlush;

    assign dstall  = (memcuDRE | memcuDWE) & ~dhit;
    assign loadUse = exMemToReg & exWEN & (exwsel != 5'd0) &
                     ((exwsel == idrs) | (exwsel == idrt));
    assign redir   = exBranchTaken | exJump;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    assign halt = (state == HALTED);

    always_comb begin
        nextState  = state;
        pcW        = 1'b0;
        ifidW      = 1'b0;
        idexW      = 1'b0;
        exmemW     = 1'b0;
        memwbW     = 1'b0;
        ifidRST    = 1'b0;
        idexRST    = 1'b0;
        exmemRST   = 1'b0;
        memwbRST   = 1'b0;
        countStall = 1'b0;
        countFlush = 1'b0;
        if (!nRST) begin
            // Held in reset: every stage register keeps loading bubbles.
            ifidRST  = 1'b1;
            idexRST  = 1'b1;
            exmemRST = 1'b1;
            memwbRST = 1'b1;
        end else if (state == RUN) begin
            if (dstall) begin
                countStall = 1'b1;
            end else if (memcuHALT) begin
                // Let the instruction ahead of HALT retire, then stop.
                memwbW    = 1'b1;
                exmemW    = 1'b1;
                exmemRST  = 1'b1;
                nextState = HALTED;
            end else if (redir) begin
                if (ihit) begin
                    pcW        = 1'b1;
                    ifidW      = 1'b1;
                    idexW      = 1'b1;
                    exmemW     = 1'b1;
                    memwbW     = 1'b1;
                    ifidRST    = 1'b1;
                    idexRST    = 1'b1;
                    countFlush = 1'b1;
                end else begin
                    countStall = 1'b1;
                end
            end else if (loadUse) begin
                idexW      = 1'b1;
                idexRST    = 1'b1;
                exmemW     = 1'b1;
                memwbW     = 1'b1;
                countStall = 1'b1;
            end else if (!ihit) begin
                ifidW      = 1'b1;
                ifidRST    = 1'b1;
                idexW      = 1'b1;
                exmemW     = 1'b1;
                memwbW     = 1'b1;
                countStall = 1'b1;
            end else begin
                pcW    = 1'b1;
                ifidW  = 1'b1;
                idexW  = 1'b1;
                exmemW = 1'b1;
                memwbW = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (countStall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (countFlush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    typedef struct packed {
        logic       ihit, dhit, dre, dwe, hlt, mtr, wen;
        logic [4:0] wsel, rs, rt;
        logic       br, jmp;
    } stim_t;

    typedef struct {
        logic [8:0] ctl;
        logic       hlt;
        int         sc, fc, sc2, fc2;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, dhit = 1'b0, memcuDRE = 1'b0, memcuDWE = 1'b0, memcuHALT = 1'b0;
    logic        exMemToReg = 1'b0, exWEN = 1'b0, exBranchTaken = 1'b0, exJump = 1'b0;
    logic [4:0]  exwsel = '0, idrs = '0, idrt = '0;

    logic        pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halt;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pcW2, ifidW2, idexW2, exmemW2, memwbW2, ifidRST2, idexRST2, exmemRST2, memwbRST2, halt2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    bit mHalted = 1'b0;
    int mSc = 0, mFc = 0, mSc2 = 0, mFc2 = 0;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memcuDRE(memcuDRE), .memcuDWE(memcuDWE),
        .memcuHALT(memcuHALT), .exMemToReg(exMemToReg), .exWEN(exWEN), .exwsel(exwsel),
        .idrs(idrs), .idrt(idrt), .exBranchTaken(exBranchTaken), .exJump(exJump),
        .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST), .memwbRST(memwbRST),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .memcuDRE(memcuDRE), .memcuDWE(memcuDWE),
        .memcuHALT(memcuHALT), .exMemToReg(exMemToReg), .exWEN(exWEN), .exwsel(exwsel),
        .idrs(idrs), .idrt(idrt), .exBranchTaken(exBranchTaken), .exJump(exJump),
        .pcW(pcW2), .ifidW(ifidW2), .idexW(idexW2), .exmemW(exmemW2), .memwbW(memwbW2),
        .ifidRST(ifidRST2), .idexRST(idexRST2), .exmemRST(exmemRST2), .memwbRST(memwbRST2),
        .halt(halt2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Situation classes: 0 reset, 1 data freeze, 2 halt taken, 3 redirect, 4 redirect wait,
    // 5 load-use bubble, 6 fetch wait, 7 normal flow, 8 halted.
    function automatic int classify(input stim_t s, input logic rstn, input bit halted);
        if (!rstn) return 0;
        if (halted) return 8;
        if ((s.dre || s.dwe) && !s.dhit) return 1;
        if (s.hlt) return 2;
        if (s.br || s.jmp) return s.ihit ? 3 : 4;
        if (s.mtr && s.wen && s.wsel != 0 && (s.wsel == s.rs || s.wsel == s.rt)) return 5;
        if (!s.ihit) return 6;
        return 7;
    endfunction

    // {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST}
    function automatic logic [8:0] ctlFor(input int c);
        case (c)
            0:       return 9'b0_0000_1111;
            2:       return 9'b0_0011_0010;
            3:       return 9'b1_1111_1100;
            5:       return 9'b0_0111_0100;
            6:       return 9'b0_1111_1000;
            7:       return 9'b1_1111_0000;
            default: return 9'b0_0000_0000;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.ihit = 1'b1;
        s.dhit = 1'b1;
        s.rs   = 5'd1;
        s.rt   = 5'd2;
        return s;
    endfunction

    function automatic stim_t rndStim();
        stim_t s;
        s.ihit = ($urandom_range(0, 3) != 0);
        s.dhit = ($urandom_range(0, 2) != 0);
        s.dre  = ($urandom_range(0, 3) == 0);
        s.dwe  = ($urandom_range(0, 5) == 0);
        s.hlt  = ($urandom_range(0, 39) == 0);
        s.mtr  = ($urandom_range(0, 2) == 0);
        s.wen  = ($urandom_range(0, 1) == 0);
        s.wsel = 5'($urandom_range(0, 7));
        s.rs   = 5'($urandom_range(0, 7));
        s.rt   = 5'($urandom_range(0, 7));
        s.br   = ($urandom_range(0, 5) == 0);
        s.jmp  = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s, input logic rstn);
        exp_t e;
        int   c;
        @(posedge CLK);
        #1;
        ihit = s.ihit; dhit = s.dhit; memcuDRE = s.dre; memcuDWE = s.dwe; memcuHALT = s.hlt;
        exMemToReg = s.mtr; exWEN = s.wen; exwsel = s.wsel; idrs = s.rs; idrt = s.rt;
        exBranchTaken = s.br; exJump = s.jmp; nRST = rstn;
        if (!rstn) begin
            mHalted = 1'b0; mSc = 0; mFc = 0; mSc2 = 0; mFc2 = 0;
        end
        c = classify(s, rstn, mHalted);
        e.ctl = ctlFor(c);
        e.hlt = mHalted;
        e.sc = mSc; e.fc = mFc; e.sc2 = mSc2; e.fc2 = mFc2;
        sb.push_back(e);
        if (c == 1 || c == 4 || c == 5 || c == 6) begin
            if (mSc < 65535) mSc++;
            if (mSc2 < 3) mSc2++;
        end
        if (c == 3) begin
            if (mFc < 65535) mFc++;
            if (mFc2 < 3) mFc2++;
        end
        if (c == 2) mHalted = 1'b1;
    endtask

    task automatic cntChk(input string name, input int sc, input int fc);
        chk({name, "_stall_cnt"}, 32'(stall_cnt), 32'(sc));
        chk({name, "_flush_cnt"}, 32'(flush_cnt), 32'(fc));
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ctl", 32'({pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST}), 32'(e.ctl));
            chk("ctl_w2", 32'({pcW2, ifidW2, idexW2, exmemW2, memwbW2, ifidRST2, idexRST2, exmemRST2, memwbRST2}), 32'(e.ctl));
            chk("halt", 32'(halt), 32'(e.hlt));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
            chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
            chk("stall_cnt_w2", 32'(stall_cnt2), 32'(e.sc2));
            chk("flush_cnt_w2", 32'(flush_cnt2), 32'(e.fc2));
        end
    end

    initial begin
        stim_t s;

        step(idle(), 1'b0);
        step(idle(), 1'b0);
        repeat (5) step(idle(), 1'b1);
        step(idle(), 1'b1);
        cntChk("no_hazard", 0, 0);

        step(idle(), 1'b0);
        s = idle(); s.mtr = 1'b1; s.wen = 1'b1; s.wsel = 5'd5; s.rs = 5'd5;
        step(s, 1'b1);
        step(idle(), 1'b1);
        cntChk("load_use", 1, 0);
        s.wsel = 5'd0; s.rs = 5'd0;
        step(s, 1'b1);
        step(idle(), 1'b1);
        cntChk("load_use_r0", 1, 0);

        step(idle(), 1'b0);
        s = idle(); s.dre = 1'b1; s.dhit = 1'b0;
        repeat (3) step(s, 1'b1);
        s.dhit = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        cntChk("data_wait", 3, 0);

        step(idle(), 1'b0);
        s = idle(); s.br = 1'b1; s.ihit = 1'b0;
        repeat (2) step(s, 1'b1);
        s.ihit = 1'b1;
        step(s, 1'b1);
        step(idle(), 1'b1);
        cntChk("branch", 2, 1);

        step(idle(), 1'b0);
        step(idle(), 1'b1);
        s = idle(); s.hlt = 1'b1;
        step(s, 1'b1);
        for (int i = 0; i < 6; i++) step(rndStim(), 1'b1);
        chk("halt_sticky", 32'(halt), 32'd1);
        cntChk("halt_frozen", 0, 0);

        step(idle(), 1'b0);
        s = idle(); s.dwe = 1'b1; s.dhit = 1'b0;
        repeat (6) step(s, 1'b1);
        step(s, 1'b1);
        chk("sat_w2_stall_cnt", 32'(stall_cnt2), 32'd3);
        chk("sat_w16_stall_cnt", 32'(stall_cnt), 32'd7 - 32'd1);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_ctl", 32'({pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST}), 32'h00f);
        chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_stall_cnt_w2", 32'(stall_cnt2), 32'd0);
        chk("async_rst_halt", 32'(halt), 32'd0);
        step(idle(), 1'b0);

        for (int i = 0; i < 600; i++) begin
            step(rndStim(), ($urandom_range(0, 29) != 0));
        end

        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage pipeline.
- Drives the per-stage write-enable (W) and flush (RST) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC write enable.
- Resolves, in a fixed priority, data-memory waits, halt, branch/jump redirects, load-use hazards and instruction-fetch waits.
- Owns the halt state and two saturating performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- memcuDRE  in  1  MEM-stage instruction reads data memory.
- memcuDWE  in  1  MEM-stage instruction writes data memory.
- memcuHALT  in  1  MEM-stage instruction is HALT.
- exMemToReg  in  1  EX-stage instruction is a load.
- exWEN  in  1  EX-stage instruction writes the register file.
- exwsel  in  5  EX-stage destination register.
- idrs  in  5  ID-stage rs field.
- idrt  in  5  ID-stage rt field.
- exBranchTaken  in  1  EX-stage branch resolved as taken.
- exJump  in  1  EX-stage jump (J/JAL/JR).
- pcW  out  1  PC loads its next value.
- ifidW, idexW, exmemW, memwbW  out  1 each  stage register loads.
- ifidRST, idexRST, exmemRST, memwbRST  out  1 each  stage register loads a bubble (all zeros) at the next edge; RST dominates W.
- halt  out  1  processor halted (registered).
- stall_cnt  out  CNT_W  cycles with pcW=0 while in RUN.
- flush_cnt  out  CNT_W  redirect flushes performed.

Behaviour:
- Clock/reset: one clock (CLK). Reset is asynchronous, active-low (nRST).
- While nRST=0:
  - state=RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - Outputs forced: all W=0, all RST=1, pcW=0.
  - An assertion mid-operation takes effect immediately, with no drain.
- States: RUN and HALTED (encoded in 1 flop). halt is the registered decode of HALTED.
- Derived terms:
  - dstall = (memcuDRE|memcuDWE) & !dhit.
  - lu = exMemToReg & exWEN & (exwsel!=0) & (exwsel==idrs | exwsel==idrt).
  - redir = exBranchTaken | exJump.
- RUN outputs are combinational. The first matching rule applies; any signal not listed is 0.
  - 1. dstall: all W=0, pcW=0 (full freeze). State stays RUN.
  - 2. memcuHALT: memwbW=1, exmemRST=1, exmemW=1. Next state=HALTED, so the instruction ahead of HALT retires.
  - 3a. redir & ihit: pcW=1; all four W=1; ifidRST=1, idexRST=1 (two wrong-path slots squashed). flush_cnt increments.
  - 3b. redir & !ihit: all W=0, pcW=0 (freeze until the fetch completes; the redirect remains presented by EX).
  - 4. lu: pcW=0, ifidW=0; idexW=1 with idexRST=1 (one bubble); exmemW=1, memwbW=1.
  - 5. !ihit: pcW=0; ifidW=1 with ifidRST=1; idexW=exmemW=memwbW=1.
  - 6. otherwise: pcW=1, all W=1, no RST.
- HALTED: all W=0, all RST=0, pcW=0, halt=1. Only nRST exits this state.
- Counters:
  - Registered, update on the CLK rising edge.
  - Saturate at 2^CNT_W-1; no wrap.
  - stall_cnt increments in RUN whenever pcW=0 and rule 2 is not taken.
  - Both counters freeze in HALTED.
- Simultaneous events: priority order as listed.
  - dstall with memcuHALT → freeze first; the halt is taken on the dhit cycle.
  - redir with lu → redirect wins; the load-use consumer is squashed.

Test Plan:
- Reset, then ihit=1 with no hazards for 5 cycles → pcW=1, all W=1, all RST=0; stall_cnt=0.
- Load-use: exMemToReg=1, exWEN=1, exwsel=5, idrs=5, ihit=1 for one cycle → pcW=0, ifidW=0, idexRST=1, stall_cnt=1. Repeating with exwsel=0 → no stall.
- Data wait: memcuDRE=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with all W=0; stall_cnt=3; the 4th cycle follows rule 6.
- Branch: exBranchTaken=1, ihit=0 for 2 cycles, then ihit=1 → 2 freeze cycles, then pcW=1, ifidRST=1, idexRST=1; flush_cnt=1; stall_cnt=2.
- Halt: memcuHALT=1 → that cycle memwbW=1, exmemRST=1; halt=1 from the next cycle and stays 1; counters frozen under continued stimulus.
- Saturation and mid-operation reset: CNT_W=2, hold dstall for 6 cycles → stall_cnt=3. Pulse nRST low mid-freeze → immediately all RST=1, W=0, counters=0, halt=0.
